game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level match sequencer for the pong game. Sits between the input/debounce logic and the ball datapath and decides when the ball moves, when it is recentred, and which way it is served. Counts points from the datapath's miss pulses, holds both scores, and declares a winner. Score and state outputs drive the on-screen score/text renderer.

Parameters:
WIN_SCORE, 11, points needed to win the match (1..2**SCORE_W-1)
SCORE_W, 4, width of each score counter
SERVE_DELAY, 120, timing_tick count spent in SERVE_WAIT before the ball is released (120 = 2 s at 60 Hz frame tick)
DLY_W, 8, width of the serve-delay counter (must hold SERVE_DELAY)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
timing_tick  in  1  one-cycle pulse per frame, same tick the ball datapath uses
start_btn  in  1  synchronised, debounced start level; the block edge-detects it internally
miss_left  in  1  one-cycle pulse: ball left the field on the left side
miss_right  in  1  one-cycle pulse: ball left the field on the right side
ball_enable  out  1  1 = ball datapath may advance on timing_tick
ball_recenter  out  1  1 = datapath holds ball at screen centre
serve_right  out  1  initial horizontal direction for the next serve (1 = right)
score_left  out  SCORE_W  left player score
score_right  out  SCORE_W  right player score
game_state  out  3  encoded FSM state for the renderer (IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4)
game_over  out  1  1 while in GAME_OVER
winner_left  out  1  valid while game_over=1; 1 = left player won

Behaviour:
- All outputs registered. Reset values: state IDLE, ball_enable 0, ball_recenter 1, serve_right 1, scores 0, game_over 0, winner_left 0, delay counter 0, start edge register 0.
- start_rise = start_btn & ~start_btn_q, with start_btn_q registered every cycle. A level held high produces exactly one rise.
- IDLE: enable 0, recenter 1. start_rise -> SERVE_WAIT. Scores cleared, serve_right 1, counter cleared, all on the same edge.
- SERVE_WAIT: enable 0, recenter 1. Counter increments on each timing_tick. On the tick where the counter equals SERVE_DELAY-1, go to PLAY and clear the counter. PLAY is therefore entered exactly SERVE_DELAY ticks after entry.
- PLAY: enable 1, recenter 0.
  - miss_left alone: score_right +1, serve_right 0 (serve toward the conceding player), go to POINT.
  - miss_right alone: score_left +1, serve_right 1, go to POINT.
  - Both in the same cycle: no score change, serve_right unchanged, go to SERVE_WAIT (replay).
- POINT: single cycle, enable 0, recenter 1.
  - score_left == WIN_SCORE: go to GAME_OVER, winner_left 1.
  - Else score_right == WIN_SCORE: go to GAME_OVER, winner_left 0.
  - Else: go to SERVE_WAIT, counter cleared.
- GAME_OVER: enable 0, recenter 1, game_over 1. Scores and winner are held. start_rise -> SERVE_WAIT with scores cleared, serve_right 1, game_over 0.
- miss pulses are ignored in every state except PLAY. start_rise is ignored in SERVE_WAIT, PLAY and POINT.
- Scores never exceed WIN_SCORE because a win always ends play, so no wrap logic is required. Counter arithmetic is unsigned, width DLY_W.
- Output timing: ball_enable/ball_recenter change on the same edge as the state register. The first tick the datapath can act on is the one after PLAY is entered.
- rst in any state restores the reset values on the next edge. A partially elapsed serve delay and the scores are discarded.
- Undefined state encodings return to IDLE.

Test Plan:
1. Reset, then start_btn held high for 10 cycles -> exactly one IDLE->SERVE_WAIT transition; PLAY entered after exactly 120 ticks; ball_enable rises with it; scores 0/0, serve_right 1.
2. In PLAY, pulse miss_left -> score_right 1, serve_right 0, POINT for 1 cycle, then SERVE_WAIT with ball_recenter 1 and ball_enable 0.
3. Drive miss_right 11 times through full serve cycles -> score_left 11, game_over 1, winner_left 1, game_state 4; extra miss pulses leave scores at 11/0.
4. miss_left and miss_right in the same PLAY cycle -> scores unchanged, serve_right unchanged, state SERVE_WAIT.
5. miss pulses in IDLE and SERVE_WAIT, and start_btn in PLAY -> no state or score change.
6. rst asserted mid-SERVE_WAIT with score 5/3 -> next cycle IDLE, scores 0/0, ball_recenter 1, ball_enable 0; start_btn from GAME_OVER -> scores cleared, SERVE_WAIT.

Source files
------------

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Match sequencer for the pong game. It decides when the ball may move, when it
// is held at the centre and which way the next serve goes. It also counts
// points from the datapath's miss pulses, holds both scores and declares the
// winner.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   timing_tick     one-cycle frame pulse shared with the ball datapath
//   start_btn       debounced start level (rising edge detected here)
//   miss_left/right one-cycle pulses: ball left the field on that side
//   ball_enable     1 = datapath may advance the ball on timing_tick
//   ball_recenter   1 = datapath holds the ball at screen centre
//   serve_right     direction of the next serve (1 = right)
//   score_left/right  player scores
//   game_state      FSM state (IDLE=0 SERVE_WAIT=1 PLAY=2 POINT=3 GAME_OVER=4)
//   game_over       1 while in GAME_OVER
//   winner_left     valid while game_over=1; 1 = left player won
//
// Handshake: there is no valid/ready pairing here. Every input is a level or a
// one-cycle pulse sampled on the rising clk edge, and every output is a
// register that updates on the same edge as the state register.
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int WIN_SCORE   = 11,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 120,
    parameter int DLY_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_enable,
    output logic               ball_recenter,
    output logic               serve_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [2:0]         game_state,
    output logic               game_over,
    output logic               winner_left
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               start_q;
    logic               start_rise;
    logic [DLY_W-1:0]   dly_cnt;
    logic               delay_done;
    logic               enable_d;
    logic               recenter_d;
    logic               game_over_d;

    assign start_rise = start_btn & ~start_q;
    // Last tick of the serve delay; the state leaves SERVE_WAIT on this tick.
    assign delay_done = timing_tick && (dly_cnt == DLY_W'(SERVE_DELAY - 1));
    assign game_state = state;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start_rise) state_d = S_SERVE_WAIT;
            end
            S_SERVE_WAIT: begin
                if (delay_done) state_d = S_PLAY;
            end
            S_PLAY: begin
                // Simultaneous misses are a replay: straight back to serving.
                if (miss_left && miss_right)     state_d = S_SERVE_WAIT;
                else if (miss_left || miss_right) state_d = S_POINT;
            end
            S_POINT: begin
                if (score_left == SCORE_W'(WIN_SCORE) ||
                    score_right == SCORE_W'(WIN_SCORE))
                    state_d = S_GAME_OVER;
                else
                    state_d = S_SERVE_WAIT;
            end
            S_GAME_OVER: begin
                if (start_rise) state_d = S_SERVE_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode (from the next state) ----------------
    // Decoding state_d and registering the result keeps the outputs aligned
    // with the state register while still coming straight from flops.
    always_comb begin
        enable_d    = (state_d == S_PLAY);
        recenter_d  = (state_d != S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ball_enable   <= 1'b0;
            ball_recenter <= 1'b1;
            game_over     <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state         <= state_d;
            ball_enable   <= enable_d;
            ball_recenter <= recenter_d;
            game_over     <= game_over_d;
            start_q       <= start_btn;
        end
    end

    // ---------------- serve-delay counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt <= '0;
        end else if (state_d == S_SERVE_WAIT && state != S_SERVE_WAIT) begin
            // Every entry into SERVE_WAIT starts a fresh delay.
            dly_cnt <= '0;
        end else if (state == S_SERVE_WAIT && timing_tick) begin
            dly_cnt <= delay_done ? '0 : dly_cnt + DLY_W'(1);
        end
    end

    // ---------------- scores, serve direction, winner ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            score_left  <= '0;
            score_right <= '0;
            serve_right <= 1'b1;
            winner_left <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start_rise) begin
                        score_left  <= '0;
                        score_right <= '0;
                        serve_right <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // The next serve goes toward the player who conceded.
                    if (miss_left && !miss_right) begin
                        score_right <= score_right + SCORE_W'(1);
                        serve_right <= 1'b0;
                    end else if (miss_right && !miss_left) begin
                        score_left  <= score_left + SCORE_W'(1);
                        serve_right <= 1'b1;
                    end
                end
                S_POINT: begin
                    if (score_left == SCORE_W'(WIN_SCORE))
                        winner_left <= 1'b1;
                    else if (score_right == SCORE_W'(WIN_SCORE))
                        winner_left <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
